// File: rtl/counter_ctrl.sv
// Command-driven initiator for an up/down loadable counter: LOAD, GOTO, SWEEP_UP, SWEEP_DOWN.
// Optional watchdog on the MOVE state is compiled in with `define CTRL_TIMEOUT_EN.
module counter_ctrl #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 2**WIDTH + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_value,
  output logic             load_n,
  output logic             ce,
  output logic             up_down,
  output logic [WIDTH-1:0] data_load,
  input  logic [WIDTH-1:0] count_out,
  input  logic             max_count,
  input  logic             zero,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_VERIFY, ST_MOVE, ST_DONE} state_t;
  typedef enum logic [1:0] {MODE_LOAD, MODE_GOTO, MODE_SWEEP_UP, MODE_SWEEP_DOWN} mode_t;

  state_t           state_q, state_d;
  mode_t            mode_q;
  logic [WIDTH-1:0] target_q;
  logic             err_q;
  logic             err_set;
  logic             accept;
  logic             at_goal;
  logic             move_up;
  logic             wd_expired;

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign data_load = target_q;
  assign err       = err_q;

  // Goal and direction are evaluated against the live count so ce drops in the
  // very cycle the goal is seen, which is what prevents overshoot.
  always_comb begin
    at_goal = 1'b1;
    move_up = 1'b1;
    case (mode_q)
      MODE_GOTO: begin
        at_goal = (count_out == target_q);
        move_up = (target_q > count_out);
      end
      MODE_SWEEP_UP: begin
        at_goal = max_count;
        move_up = 1'b1;
      end
      MODE_SWEEP_DOWN: begin
        at_goal = zero;
        move_up = 1'b0;
      end
      default: begin
        at_goal = 1'b1;
        move_up = 1'b1;
      end
    endcase
  end

`ifdef CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  logic [WD_W-1:0] wd_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != ST_MOVE) wd_q <= '0;
    else                           wd_q <= wd_q + WD_W'(1);
  end

  assign wd_expired = (wd_q == WD_W'(TIMEOUT));
`else
  assign wd_expired = 1'b0;
`endif

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    load_n  = 1'b1;
    ce      = 1'b0;
    up_down = 1'b1;
    busy    = 1'b1;
    done    = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (accept) state_d = (mode_t'(cmd_mode) == MODE_LOAD) ? ST_LOAD : ST_MOVE;
      end
      ST_LOAD: begin
        load_n  = rst;
        state_d = ST_VERIFY;
      end
      ST_VERIFY: begin
        err_set = (count_out != target_q);
        state_d = ST_DONE;
      end
      ST_MOVE: begin
        up_down = move_up;
        if (at_goal) begin
          state_d = ST_DONE;
        end else if (wd_expired) begin
          err_set = 1'b1;
          state_d = ST_DONE;
        end else begin
          // Gated by rst so an aborted command leaves the counter where it is.
          ce = !rst;
        end
      end
      ST_DONE: begin
        done    = !rst;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: reset is synchronous here, sampled on the clock edge like any other input.
  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_LOAD;
      target_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q   <= mode_t'(cmd_mode);
        target_q <= cmd_value;
        err_q    <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl driving a behavioural up/down loadable counter.
// Expected outcomes are predicted from a shadow count when each command is issued.
module tb_counter_ctrl;

  localparam logic [1:0] M_LOAD  = 2'b00;
  localparam logic [1:0] M_GOTO  = 2'b01;
  localparam logic [1:0] M_SWUP  = 2'b10;
  localparam logic [1:0] M_SWDN  = 2'b11;
  localparam int         BUDGET  = 60;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [3:0] cmd_value;
  logic       load_n;
  logic       ce;
  logic       up_down;
  logic [3:0] data_load;
  logic [3:0] count_out;
  logic       max_count;
  logic       zero;
  logic       busy;
  logic       done;
  logic       err;

  logic [3:0] cnt = 4'h0;
  logic       ignore_ce = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      name;
    logic [3:0] cnt;
    logic       err;
    int         lat;
    int         ce_cyc;
    int         strobes;
    logic       up;
    logic [3:0] tgt;
    logic       goto;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] shadow = 4'h0;

  counter_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_value (cmd_value),
    .load_n    (load_n),
    .ce        (ce),
    .up_down   (up_down),
    .data_load (data_load),
    .count_out (count_out),
    .max_count (max_count),
    .zero      (zero),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Attached counter; ignore_ce models a broken counter for the watchdog case.
  always @(posedge clk) begin
    if (!load_n)                cnt <= data_load;
    else if (ce && !ignore_ce)  cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
  end
  assign count_out = cnt;
  assign max_count = &cnt;
  assign zero      = (cnt == 4'h0);

  task automatic cmp(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [1:0] mode, input logic [3:0] val, input string name);
    exp_t e;
    int   s;
    int   v;
    s = int'(shadow);
    v = int'(val);
    e.name = name; e.err = 1'b0; e.strobes = 0; e.up = 1'b1; e.tgt = val; e.goto = 1'b0;
    case (mode)
      M_LOAD: begin e.cnt = val;  e.ce_cyc = 0;      e.lat = 3;          e.strobes = 1; end
      M_GOTO: begin
        e.cnt = val; e.goto = 1'b1; e.up = (v > s);
        e.ce_cyc = (v > s) ? v - s : s - v;
        e.lat = e.ce_cyc + 2;
      end
      M_SWUP: begin e.cnt = 4'hF; e.ce_cyc = 15 - s; e.lat = 17 - s; end
      default: begin e.cnt = 4'h0; e.up = 1'b0; e.ce_cyc = s; e.lat = s + 2; end
    endcase
    shadow = e.cnt;
    sb.push_back(e);
  endtask

  task automatic send(input logic [1:0] mode, input logic [3:0] val);
    @(negedge clk);
    if (cmd_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL ready_before_cmd: got %b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_value = val;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_value = ~val;
  endtask

  task automatic wait_done();
    exp_t e;
    int   ce_n = 0;
    int   st_n = 0;
    bit   got  = 1'b0;
    e = sb[0];
    for (int cyc = 1; cyc <= BUDGET && !got; cyc++) begin
      @(negedge clk);
      if (cyc == 1) cmp({e.name, " err_cleared_on_accept"}, int'(err), 0);
      if (!load_n && ce) cmp({e.name, " load_ce_overlap"}, 1, 0);
      if (!load_n) begin
        st_n++;
        cmp({e.name, " data_load_at_strobe"}, int'(data_load), int'(e.tgt));
      end
      if (ce) begin
        ce_n++;
        if (up_down !== e.up) cmp({e.name, " up_down"}, int'(up_down), int'(e.up));
        if (e.goto && count_out == e.tgt) cmp({e.name, " ce_at_target"}, 1, 0);
      end
      if (done === 1'b1) begin
        got = 1'b1;
        e = sb.pop_front();
        cmp({e.name, " latency"},   cyc,             e.lat);
        cmp({e.name, " count_out"}, int'(count_out), int'(e.cnt));
        cmp({e.name, " err"},       int'(err),       int'(e.err));
        cmp({e.name, " ce_cycles"}, ce_n,            e.ce_cyc);
        cmp({e.name, " strobes"},   st_n,            e.strobes);
        cmp({e.name, " data_load"}, int'(data_load), int'(e.tgt));
      end
    end
    if (!got) begin
      e = sb.pop_front();
      vectors++; miscompares++;
      $display("FAIL %s done_timeout: got no done expected done within %0d cycles", e.name, BUDGET);
    end
    @(negedge clk);
    cmp({e.name, " done_one_cycle"}, int'(done), 0);
    cmp({e.name, " idle_after"},     int'(busy), 0);
  endtask

  task automatic run(input logic [1:0] mode, input logic [3:0] val, input string name);
    push_exp(mode, val, name);
    send(mode, val);
    wait_done();
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_mode = M_GOTO; cmd_value = 4'h7;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      cmp("rst cmd_ready", int'(cmd_ready), 0);
      cmp("rst load_n",    int'(load_n),    1);
      cmp("rst ce",        int'(ce),        0);
      cmp("rst up_down",   int'(up_down),   1);
      cmp("rst busy",      int'(busy),      0);
      cmp("rst done",      int'(done),      0);
      cmp("rst err",       int'(err),       0);
      cmp("rst data_load", int'(data_load), 0);
    end
    cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    cmp("post_rst no_accept busy", int'(busy), 0);
    cmp("post_rst cmd_ready",      int'(cmd_ready), 1);
  endtask

  task automatic test_load();
    run(M_LOAD, 4'hA, "load_A");
    run(M_LOAD, 4'h3, "load_3");
  endtask

  task automatic test_goto();
    run(M_GOTO, 4'h7, "goto_up_7");
    run(M_GOTO, 4'h2, "goto_down_2");
    run(M_GOTO, 4'h2, "goto_same_2");
  endtask

  task automatic test_sweep();
    run(M_LOAD, 4'h0, "load_0");
    run(M_SWDN, 4'h5, "sweep_down_at_zero");
    run(M_SWUP, 4'h9, "sweep_up_from_0");
    run(M_SWUP, 4'h1, "sweep_up_at_max");
    run(M_GOTO, 4'h0, "goto_F_to_0");
  endtask

  task automatic test_reset_abort();
    bit seen = 1'b0;
    run(M_LOAD, 4'h0, "abort_preload");
    send(M_GOTO, 4'hF);
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clk);
      if (count_out == 4'h5) seen = 1'b1;
    end
    cmp("abort reached_5", int'(seen), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cmp("abort busy",      int'(busy),      0);
    cmp("abort ce",        int'(ce),        0);
    cmp("abort load_n",    int'(load_n),    1);
    cmp("abort cmd_ready", int'(cmd_ready), 0);
    cmp("abort count",     int'(count_out), 5);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || count_out !== 4'h5 || busy !== 1'b0) begin
        vectors++; miscompares++;
        $display("FAIL abort_quiet: got done=%b count=%h busy=%b expected 0/5/0", done, count_out, busy);
      end
    end
    vectors++;
    shadow = 4'h5;
    run(M_GOTO, 4'h8, "goto_after_abort");
  endtask

`ifdef CTRL_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    run(M_LOAD, 4'h0, "wd_preload");
    ignore_ce = 1'b1;
    e.name = "wd_goto_9"; e.cnt = 4'h0; e.err = 1'b1; e.lat = 20; e.ce_cyc = 18;
    e.strobes = 0; e.up = 1'b1; e.tgt = 4'h9; e.goto = 1'b1;
    sb.push_back(e);
    send(M_GOTO, 4'h9);
    wait_done();
    cmp("wd err_sticky", int'(err), 1);
    ignore_ce = 1'b0;
    shadow = 4'h0;
    run(M_LOAD, 4'h3, "wd_next_clears_err");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_goto();
    test_sweep();
    test_reset_abort();
`ifdef CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
